// File: rtl/serial_frame_receiver_if.sv
// Serial frame receiver bus: strobed bit input, decoded byte and status out.
// master drives the line side, slave is the receiver.
interface serial_frame_receiver_if #(
    parameter int DATA_BITS = 8
);
    logic                 i_strobe;
    logic                 i_dat;
    logic [DATA_BITS-1:0] o_data;
    logic                 o_valid;
    logic                 o_err;
    logic                 o_busy;

    modport master (
        output i_strobe, i_dat,
        input  o_data, o_valid, o_err, o_busy
    );

    modport slave (
        input  i_strobe, i_dat,
        output o_data, o_valid, o_err, o_busy
    );
endinterface

// File: rtl/serial_frame_receiver.sv
// Start/data/parity/stop deserialiser sampling on one-cycle strobes,
// with an idle-timeout that aborts stalled frames.
module serial_frame_receiver #(
    parameter int DATA_BITS  = 8,
    parameter bit PARITY_ODD = 1'b1,
    parameter int TIMEOUT    = 1024
) (
    input  logic                   clk,
    input  logic                   i_sclr,
    input  logic                   i_en,
    serial_frame_receiver_if.slave bus
);
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam int TW = $clog2(TIMEOUT);
    localparam logic [BW-1:0] LAST = BW'(DATA_BITS - 1);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    state_t               state_q, state_d;
    logic [DATA_BITS-1:0] sr_q, sr_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic [BW-1:0]        bcnt_q, bcnt_d;
    logic [TW-1:0]        tcnt_q, tcnt_d;
    logic                 par_q, par_d;
    logic                 valid_q, valid_d;
    logic                 err_q, err_d;
    logic                 busy_q;
    logic                 stb;
    logic                 good;

    assign stb  = i_en & bus.i_strobe;
    assign good = bus.i_dat & ((^sr_q ^ par_q) == PARITY_ODD);

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        data_d  = data_q;
        bcnt_d  = bcnt_q;
        tcnt_d  = tcnt_q;
        par_d   = par_q;
        valid_d = 1'b0;
        err_d   = 1'b0;
        if (i_en && state_q != IDLE) begin
            if (stb) begin
                tcnt_d = '0;
            end else if (tcnt_q == TMAX) begin
                // stalled frame: abort and report
                state_d = IDLE;
                err_d   = 1'b1;
                tcnt_d  = '0;
                bcnt_d  = '0;
            end else begin
                tcnt_d = tcnt_q + 1'b1;
            end
        end
        if (stb) begin
            unique case (state_q)
                IDLE: begin
                    if (!bus.i_dat) begin
                        state_d = DATA;
                        bcnt_d  = '0;
                        tcnt_d  = '0;
                    end
                end
                DATA: begin
                    sr_d = sr_q >> 1;
                    sr_d[DATA_BITS-1] = bus.i_dat;
                    bcnt_d = bcnt_q + 1'b1;
                    if (bcnt_q == LAST) state_d = PARITY;
                end
                PARITY: begin
                    par_d   = bus.i_dat;
                    state_d = STOP;
                end
                STOP: begin
                    state_d = IDLE;
                    if (good) begin
                        data_d  = sr_q;
                        valid_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (i_sclr) begin
            state_q <= IDLE;
            sr_q    <= '0;
            data_q  <= '0;
            bcnt_q  <= '0;
            tcnt_q  <= '0;
            par_q   <= 1'b0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            data_q  <= data_d;
            bcnt_q  <= bcnt_d;
            tcnt_q  <= tcnt_d;
            par_q   <= par_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            busy_q  <= (state_d != IDLE);
        end
    end

    assign bus.o_data  = data_q;
    assign bus.o_valid = valid_q;
    assign bus.o_err   = err_q;
    assign bus.o_busy  = busy_q;
endmodule

// File: tb/tb_serial_frame_receiver.sv
// Scoreboard bench for serial_frame_receiver: directed frames push
// expected pulses, a negedge monitor pops and compares them.
module tb_serial_frame_receiver;
    logic clk = 1'b0;
    logic i_sclr;
    logic i_en;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    logic [7:0] model_data = 8'h00;

    typedef struct {
        logic       err;
        logic [7:0] data;
        int         due;
    } exp_t;
    exp_t q[$];

    serial_frame_receiver_if #(.DATA_BITS(8)) bus ();

    serial_frame_receiver #(
        .DATA_BITS(8),
        .PARITY_ODD(1'b1),
        .TIMEOUT(16)
    ) dut (
        .clk(clk),
        .i_sclr(i_sclr),
        .i_en(i_en),
        .bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (bus.o_valid && bus.o_err) chk("valid_and_err", 1, 0);
        if (bus.o_valid || bus.o_err) begin
            if (q.size() == 0) begin
                chk("unexpected_pulse", {bus.o_valid, bus.o_err}, 0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("pulse_kind_err", bus.o_err, e.err);
                chk("pulse_data", bus.o_data, e.data);
                chk("pulse_cycle", cyc, e.due);
            end
        end
    end

    task automatic gap(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic b);
        bus.i_strobe = 1'b1;
        bus.i_dat    = b;
        @(posedge clk);
        #1;
        bus.i_strobe = 1'b0;
        bus.i_dat    = 1'b1;
    endtask

    task automatic send_body(input logic [7:0] d, input logic p,
                             input logic s, input int sp);
        for (int i = 0; i < 8; i++) begin
            strobe(d[i]);
            gap(sp);
        end
        strobe(p);
        gap(sp);
        strobe(s);
    endtask

    task automatic expect_after(input logic is_err, input logic [7:0] d);
        if (!is_err) model_data = d;
        q.push_back('{is_err, model_data, cyc});
    endtask

    task automatic frame(input logic [7:0] d, input logic p, input logic s,
                         input int sp, input logic is_err);
        strobe(1'b0);
        gap(sp);
        send_body(d, p, s, sp);
        expect_after(is_err, d);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int last;
        i_sclr = 1'b1;
        i_en   = 1'b1;
        bus.i_strobe = 1'b0;
        bus.i_dat    = 1'b1;
        gap(2);
        chk("rst_data", bus.o_data, 0);
        chk("rst_valid", bus.o_valid, 0);
        chk("rst_err", bus.o_err, 0);
        chk("rst_busy", bus.o_busy, 0);
        i_sclr = 1'b0;
        gap(2);

        // good 0x5A, odd parity 1
        strobe(1'b0);
        chk("busy_after_start", bus.o_busy, 1);
        gap(2);
        send_body(8'h5A, 1'b1, 1'b1, 2);
        expect_after(1'b0, 8'h5A);
        chk("busy_after_stop", bus.o_busy, 0);
        gap(4);
        chk("data_hold", bus.o_data, 8'h5A);

        // parity error
        frame(8'h5A, 1'b0, 1'b1, 1, 1'b1);
        gap(3);
        // stop error
        frame(8'h3C, 1'b1, 1'b0, 1, 1'b1);
        gap(3);

        // idle noise
        for (int i = 0; i < 3; i++) begin
            strobe(1'b1);
            chk("idle_noise_busy", bus.o_busy, 0);
        end

        // timeout after start + 3 data bits
        strobe(1'b0);
        strobe(1'b1);
        strobe(1'b0);
        strobe(1'b1);
        last = cyc;
        q.push_back('{1'b1, model_data, last + 16});
        gap(15);
        chk("busy_before_timeout", bus.o_busy, 1);
        gap(1);
        chk("busy_after_timeout", bus.o_busy, 0);
        gap(3);
        frame(8'hA5, 1'b1, 1'b1, 2, 1'b0);
        gap(3);

        // reset while in PARITY
        strobe(1'b0);
        for (int i = 0; i < 8; i++) strobe(1'b1);
        i_sclr = 1'b1;
        gap(1);
        chk("sclr_data", bus.o_data, 0);
        chk("sclr_valid", bus.o_valid, 0);
        chk("sclr_err", bus.o_err, 0);
        chk("sclr_busy", bus.o_busy, 0);
        model_data = 8'h00;
        i_sclr = 1'b0;
        gap(2);

        // enable low freezes the timeout counter
        strobe(1'b0);
        gap(3);
        i_en = 1'b0;
        gap(40);
        chk("freeze_busy", bus.o_busy, 1);
        i_en = 1'b1;
        gap(2);
        send_body(8'h96, 1'b1, 1'b1, 2);
        expect_after(1'b0, 8'h96);
        gap(3);

        // back-to-back frames
        frame(8'h01, 1'b0, 1'b1, 0, 1'b0);
        frame(8'hFF, 1'b1, 1'b1, 0, 1'b0);
        chk("b2b_busy_low", bus.o_busy, 0);

        for (int i = 0; i < 50 && q.size() > 0; i++) gap(1);
        gap(2);
        chk("pending_expectations", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/serial_frame_receiver.md
# serial_frame_receiver

Deserialises a start/data/parity/stop serial frame from a single-bit line, sampling only on one-cycle strobes. It sits directly downstream of the edge detector: that block's `o_posedge` drives `i_strobe`, and the same synchronised line drives `i_dat`. Completed bytes are presented as `o_data` with a one-cycle `o_valid` pulse for the string-assembly logic. Malformed or stalled frames raise a one-cycle `o_err` pulse.

## Interface
Parameters:
- `DATA_BITS`, default 8: payload bits per frame, LSB first.
- `PARITY_ODD`, default 1: 1 selects odd parity, 0 selects even.
- `TIMEOUT`, default 1024: enabled cycles without a strobe before a partial frame is aborted. Must be ≥ 2.

Ports:
- `clk`, in, 1: the single clock; all logic on the rising edge.
- `i_sclr`, in, 1: reset, synchronous and active-high.
- `i_en`, in, 1: clock enable. When low, all state, including the timeout counter, holds.
- `i_strobe`, in, 1: bit-sample pulse. Only effective when `i_en` = 1.
- `i_dat`, in, 1: serial data, already synchronised.
- `o_data`, out, `DATA_BITS`: last good payload. Holds until the next good frame.
- `o_valid`, out, 1: one-cycle pulse when `o_data` has just been updated.
- `o_err`, out, 1: one-cycle pulse on a parity error, stop-bit error or timeout.
- `o_busy`, out, 1: high whenever the FSM is not in IDLE.

## Operation
- A strobe is effective when `i_strobe` & `i_en` = 1.
- FSM states: IDLE, DATA, PARITY, STOP.
- **IDLE:**
  - Effective strobe with `i_dat` = 0 (start bit): go to DATA, clear the bit counter, clear the timeout counter.
  - Effective strobe with `i_dat` = 1: ignored, no error.
- **DATA:**
  - Each effective strobe shifts `i_dat` into the shift register MSB side, shifting right, so the first bit received ends at bit 0.
  - The bit counter increments on each such strobe.
  - On the `DATA_BITS`-th strobe, go to PARITY.
- **PARITY:** an effective strobe latches `i_dat` as the parity bit and goes to STOP.
- **STOP:** an effective strobe always returns to IDLE.
  - The frame is good when `i_dat` = 1 and (XOR of shift register and parity bit) = `PARITY_ODD`.
  - Good frame: load `o_data` from the shift register and pulse `o_valid`.
  - Otherwise: pulse `o_err`; `o_data` is unchanged.
- **Timeout:**
  - Outside IDLE, the counter increments on each `i_en` cycle without an effective strobe.
  - Any effective strobe clears it.
  - When it reaches `TIMEOUT`-1 with no strobe in that cycle: go to IDLE, pulse `o_err`, discard the partial frame.
- **Simultaneous events:**
  - A strobe in the same cycle as timeout expiry wins; no timeout occurs.
  - `i_sclr` overrides everything.
- **Widths:**
  - Bit counter width is clog2(`DATA_BITS`+1).
  - Timeout counter width is clog2(`TIMEOUT`); it never wraps, because it is cleared on expiry.
- `o_valid` and `o_err` are never high in the same cycle.

## Timing
- Reset values, one cycle after `i_sclr` high:
  - state = IDLE
  - `o_data` = 0, `o_valid` = 0, `o_err` = 0, `o_busy` = 0
  - all counters = 0
- Reset mid-frame: the partial frame is dropped, with no `o_err` and no `o_valid`.
- All outputs are registered.
- `o_valid` / `o_err` rise in cycle N+1 for a stop strobe in cycle N, and last exactly one cycle.
- `o_busy` rises in cycle N+1 after the start strobe. It falls in cycle N+1 after the stop strobe or timeout.
- Back-to-back frames:
  - A start strobe is accepted in the cycle immediately after leaving STOP.
  - No dead cycle is required beyond the strobe spacing.
- With `i_en` low, no output changes except pulse deassertion. `o_valid` / `o_err` still drop after one cycle.

## Test plan
1. **Good frame:** strobes with `i_dat` = 0 | 0,1,0,1,1,0,1,0 | 1 | 1 (start | data 0x5A LSB first | odd parity | stop). Expect `o_data` = 0x5A and `o_valid` = 1 for exactly one cycle, one cycle after the stop strobe. `o_err` stays 0.
2. **Parity error:** same frame with parity bit 0. Expect an `o_err` pulse, no `o_valid`, and `o_data` keeps its previous value.
3. **Stop error and idle noise:**
   - Good 0x3C frame with stop bit 0: expect an `o_err` pulse, no `o_valid`.
   - Strobes with `i_dat` = 1 in IDLE: no response, `o_busy` stays 0.
4. **Timeout:** with `TIMEOUT` = 16, send start plus 3 data bits, then hold `i_en` = 1 with no strobes. Expect `o_err` 16 cycles after the last strobe and `o_busy` to fall. A following good 0xA5 frame must then decode correctly.
5. **Reset mid-frame:**
   - Assert `i_sclr` during PARITY: all outputs must be 0 next cycle, with no pulses.
   - Toggle `i_en` low between strobes: the timeout counter must freeze.
6. **Back-to-back frames:** 0x01 then 0xFF, with the second start strobe in the cycle after the first stop strobe. Expect two `o_valid` pulses with `o_data` 0x01 then 0xFF.
